// File: rtl/altr_hps_rst_seq_pkg.sv
// Shared types and parameter limits for the staged reset-release sequencer.
package altr_hps_rst_seq_pkg;

  typedef enum logic [2:0] {
    S_HOLD   = 3'd0,
    S_ACK    = 3'd1,
    S_DONE   = 3'd2,
    S_WARM   = 3'd3,
    S_WQUIET = 3'd4
  } state_e;

  localparam int unsigned STAGE_IDX_W = 3;

  localparam int unsigned STAGES_MIN  = 1;
  localparam int unsigned STAGES_MAX  = 8;
  localparam int unsigned GAP_MIN     = 1;
  localparam int unsigned GAP_MAX     = 255;
  localparam int unsigned ACK_TO_MAX  = 255;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/altr_hps_rst_seq_cntr.sv
// Clearable saturating up-counter with terminal-count compare; shared by the
// release-gap, warm-assert spacing and ack-timeout functions.
module altr_hps_rst_seq_cntr #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SAT_VAL = 255
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [WIDTH-1:0] tc_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             tc_hit_o
);

  localparam logic [WIDTH-1:0] SAT = WIDTH'(SAT_VAL);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != SAT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign tc_hit_o = (cnt_q == tc_i);

endmodule

// File: rtl/altr_hps_rst_seq.sv
// Staged reset-release sequencer: releases NUM_STAGES reset domains in order,
// gated by per-stage acks, and replays the sequence after a warm-reset request.
module altr_hps_rst_seq
  import altr_hps_rst_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES  = 4,
  parameter int unsigned GAP_CYC     = 8,
  parameter int unsigned ACK_TIMEOUT = 64,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   i_rst_n,
  input  logic                   i_warm_req,
  input  logic [NUM_STAGES-1:0]  i_stage_ack,
  output logic [NUM_STAGES-1:0]  o_stage_rst_n,
  output logic                   o_seq_done,
  output logic                   o_timeout_err,
  output logic [STAGE_IDX_W-1:0] o_cur_stage
);

  localparam int unsigned          CNT_MAX  = max_u(GAP_CYC, ACK_TIMEOUT) - 1;
  localparam logic [CNT_WIDTH-1:0] GAP_TC   = CNT_WIDTH'(GAP_CYC - 1);
  localparam logic [CNT_WIDTH-1:0] ACK_TC   = CNT_WIDTH'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
  localparam logic [STAGE_IDX_W-1:0] LAST_IDX = STAGE_IDX_W'(NUM_STAGES - 1);

  state_e                 state_q;
  logic [STAGE_IDX_W-1:0] idx_q;
  logic [NUM_STAGES-1:0]  rst_q;
  logic                   done_q;
  logic                   err_q;

  logic [CNT_WIDTH-1:0]   cnt;
  logic [CNT_WIDTH-1:0]   cnt_tc;
  logic                   cnt_hit;
  logic                   cnt_zero;
  logic                   cnt_clr;
  logic                   cnt_inc;
  logic [NUM_STAGES-1:0]  idx_mask;
  logic                   ack_sel;
  logic                   ack_adv;
  logic                   ack_to;
  logic                   warm_last;

  assign idx_mask  = NUM_STAGES'(1) << idx_q;
  assign ack_sel   = |(i_stage_ack & idx_mask);
  assign cnt_tc    = (state_q == S_ACK) ? ACK_TC : GAP_TC;
  assign cnt_zero  = (cnt == '0);
  assign ack_adv   = (ACK_TIMEOUT == 0) || ack_sel || cnt_hit;
  // An ack seen on the timeout cycle wins; the error is only flagged without it.
  assign ack_to    = (ACK_TIMEOUT != 0) && !ack_sel && cnt_hit;
  assign warm_last = cnt_zero && (idx_q == '0);

  always_comb begin
    cnt_clr = 1'b1;
    cnt_inc = 1'b0;
    unique case (state_q)
      S_HOLD: begin
        cnt_clr = cnt_hit;
        cnt_inc = !cnt_hit;
      end
      S_ACK: begin
        cnt_clr = ack_adv;
        cnt_inc = !ack_adv;
      end
      S_WARM: begin
        cnt_clr = warm_last || cnt_hit;
        cnt_inc = !(warm_last || cnt_hit);
      end
      default: begin
        cnt_clr = 1'b1;
        cnt_inc = 1'b0;
      end
    endcase
  end

  altr_hps_rst_seq_cntr #(
    .WIDTH   (CNT_WIDTH),
    .SAT_VAL (CNT_MAX)
  ) u_cntr (
    .clk_i    (clk),
    .rst_ni   (i_rst_n),
    .clr_i    (cnt_clr),
    .inc_i    (cnt_inc),
    .tc_i     (cnt_tc),
    .cnt_o    (cnt),
    .tc_hit_o (cnt_hit)
  );

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_HOLD;
      idx_q   <= '0;
      rst_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_HOLD: begin
          if (cnt_hit) begin
            rst_q   <= rst_q | idx_mask;
            state_q <= S_ACK;
          end
        end
        S_ACK: begin
          if (ack_adv) begin
            if (ack_to) err_q <= 1'b1;
            if (idx_q == LAST_IDX) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= S_HOLD;
            end
          end
        end
        S_DONE: begin
          if (i_warm_req) begin
            done_q  <= 1'b0;
            idx_q   <= LAST_IDX;
            state_q <= S_WARM;
          end
        end
        S_WARM: begin
          // Assert the current stage at the start of each gap window.
          if (cnt_zero) rst_q <= rst_q & ~idx_mask;
          if (warm_last) begin
            state_q <= S_WQUIET;
          end else if (cnt_hit) begin
            idx_q <= idx_q - 1'b1;
          end
        end
        S_WQUIET: begin
          if (!i_warm_req) begin
            idx_q   <= '0;
            state_q <= S_HOLD;
          end
        end
        default: begin
          state_q <= S_HOLD;
        end
      endcase
    end
  end

  assign o_stage_rst_n = rst_q;
  assign o_seq_done    = done_q;
  assign o_timeout_err = err_q;
  assign o_cur_stage   = idx_q;

`ifdef ALTR_HPS_SIMULATION
  initial begin
    if ((NUM_STAGES < STAGES_MIN) || (NUM_STAGES > STAGES_MAX) ||
        (GAP_CYC < GAP_MIN) || (GAP_CYC > GAP_MAX) ||
        (ACK_TIMEOUT > ACK_TO_MAX) ||
        ((64'd1 << CNT_WIDTH) <= 64'(max_u(GAP_CYC, ACK_TIMEOUT)))) begin
      $display("altr_hps_rst_seq: illegal parameters N=%0d GAP=%0d TO=%0d W=%0d",
               NUM_STAGES, GAP_CYC, ACK_TIMEOUT, CNT_WIDTH);
      $finish;
    end
  end
`endif

endmodule

// File: tb/tb_altr_hps_rst_seq.sv
// Scoreboard bench for altr_hps_rst_seq: an event-schedule model predicts every
// output change (cycle and value); a monitor compares whenever outputs move.
`timescale 1ns/1ps
module tb_altr_hps_rst_seq;

  localparam int unsigned N = 4;
  localparam int unsigned G = 8;
  localparam int unsigned T = 64;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, warm;
  logic [N-1:0] ack;
  logic [N-1:0] o_rst;
  logic         o_done, o_err;
  logic [2:0]   o_cur;

  logic         rst1_n, warm1, ack1;
  logic         o1_rst, o1_done, o1_err;
  logic [2:0]   o1_cur;

  altr_hps_rst_seq dut (
    .clk(clk), .i_rst_n(rst_n), .i_warm_req(warm), .i_stage_ack(ack),
    .o_stage_rst_n(o_rst), .o_seq_done(o_done), .o_timeout_err(o_err), .o_cur_stage(o_cur)
  );

  altr_hps_rst_seq #(.NUM_STAGES(1), .GAP_CYC(1), .ACK_TIMEOUT(0), .CNT_WIDTH(8)) dut1 (
    .clk(clk), .i_rst_n(rst1_n), .i_warm_req(warm1), .i_stage_ack(ack1),
    .o_stage_rst_n(o1_rst), .o_seq_done(o1_done), .o_timeout_err(o1_err), .o_cur_stage(o1_cur)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
  endfunction

  // Reference model: expected output changes as an ordered schedule.
  typedef struct {
    int unsigned  at;
    logic [N-1:0] rst;
    logic         done;
    logic         err;
  } ev_t;
  ev_t exp_q[$];

  logic [N-1:0] m_rst;
  logic         m_done, m_err;
  int unsigned  dly [N];

  function automatic void emit(input int unsigned at);
    ev_t e;
    e.at = at; e.rst = m_rst; e.done = m_done; e.err = m_err;
    if (exp_q.size() > 0 && exp_q[exp_q.size()-1].at == at) exp_q[exp_q.size()-1] = e;
    else exp_q.push_back(e);
  endfunction

  // Stage k releases G cycles after the previous advance; advance happens when
  // the ack is seen (dly cycles after release) or after T cycles with an error.
  function automatic int unsigned model_release(input int unsigned start);
    int unsigned t, r, d;
    logic [N-1:0] one;
    one = 1;
    t = start;
    for (int k = 0; k < N; k++) begin
      r = t + G;
      m_rst = m_rst | (one << k);
      emit(r);
      d = (dly[k] == 0) ? 1 : dly[k];
      if (d <= T) t = r + d;
      else begin t = r + T; m_err = 1'b1; end
      if (k == N - 1) m_done = 1'b1;
      if (k == N - 1 || d > T) emit(t);
    end
    return t;
  endfunction

  // Warm accepted at edge e: done drops, stages assert high-to-low G apart,
  // release restarts once the request is low and stage 0 is down.
  function automatic int unsigned model_warm(input int unsigned e, input int unsigned l);
    int unsigned e0;
    logic [N-1:0] one;
    one = 1;
    m_done = 1'b0;
    emit(e);
    for (int i = 0; i < N; i++) begin
      m_rst = m_rst & ~(one << (N - 1 - i));
      emit(e + 1 + i * G);
    end
    e0 = e + 1 + (N - 1) * G;
    return (l > e0 + 1) ? l : e0 + 1;
  endfunction

  // Monitor: compares against the head of the schedule on any output change.
  initial begin
    logic [N+1:0] prev, cur;
    ev_t e;
    prev = '0;
    forever begin
      @(posedge clk);
      #1;
      cur = {o_rst, o_done, o_err};
      if (!rst_n) begin
        prev = cur;
        continue;
      end
      if (cur != prev || (exp_q.size() > 0 && exp_q[0].at == cyc)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_change", 32'(cur), 32'(prev));
        end else begin
          e = exp_q.pop_front();
          chk("ev_cycle", cyc, e.at);
          chk("ev_outputs", 32'(cur), 32'({e.rst, e.done, e.err}));
        end
      end
      prev = cur;
    end
  end

  // Stage responder: ack rises dly cycles after release; unreleased stages
  // drive random ack noise that the DUT must ignore.
  initial begin
    int unsigned hi [N];
    ack = '0;
    for (int k = 0; k < N; k++) hi[k] = 0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        if (o_rst[k]) hi[k]++; else hi[k] = 0;
        if (hi[k] == 0) ack[k] = 1'($urandom_range(0, 1));
        else ack[k] = (hi[k] >= dly[k]);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic goto_neg(input int unsigned c);
    @(negedge clk);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic cold_start(output int unsigned c0, output int unsigned done_at);
    m_rst = '0; m_done = 1'b0; m_err = 1'b0;
    exp_q.delete();
    @(negedge clk);
    c0 = cyc;
    done_at = model_release(c0);
    rst_n = 1'b1;
  endtask

  task automatic do_warm(input int unsigned done_at, input int unsigned w, output int unsigned new_done);
    int unsigned c, x;
    goto_neg(done_at + 1 + $urandom_range(0, 4));
    c = cyc;
    x = model_warm(c + 1, c + w + 1);
    new_done = model_release(x);
    warm = 1'b1;
    goto_neg(c + w);
    warm = 1'b0;
  endtask

  task automatic hard_reset(input bit drained, input string tag);
    @(negedge clk);
    if (drained) chk({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    chk({tag, "_async_rst_outputs"}, 32'({o_rst, o_done, o_err, o_cur}), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int unsigned c0, d, d2;
    rst_n = 1'b0; warm = 1'b0;
    rst1_n = 1'b0; warm1 = 1'b0; ack1 = 1'b0;
    for (int k = 0; k < N; k++) dly[k] = 1;
    #1;
    chk("reset_values", 32'({o_rst, o_done, o_err, o_cur}), 32'd0);
    repeat (3) @(negedge clk);

    // Cold release with acks immediately high, then a 50-cycle warm reset.
    cold_start(c0, d);
    goto_neg(d + 1);
    chk("cur_stage_done", 32'(o_cur), 32'(N - 1));
    do_warm(d, 50, d2);
    goto_neg(d2 + 2);
    hard_reset(1'b1, "cold_warm");

    // Stage 1 ack arrives 20 cycles after its release.
    dly = '{1, 20, 1, 1};
    cold_start(c0, d);
    goto_neg(d + 2);
    hard_reset(1'b1, "ack_delay");

    // Stage 2 never acks: timeout, then warm reset keeps the sticky error.
    dly = '{1, 1, 1000, 1};
    cold_start(c0, d);
    do_warm(d, 50, d2);
    goto_neg(d2 + 2);
    chk("err_sticky_after_warm", 32'(o_err), 32'd1);
    hard_reset(1'b1, "timeout");

    // Reset while only stages 0 and 1 are released, then a clean restart.
    dly = '{1, 1, 1, 1};
    cold_start(c0, d);
    goto_neg(c0 + 19);
    hard_reset(1'b0, "midseq");
    cold_start(c0, d);
    goto_neg(d + 2);
    hard_reset(1'b1, "restart");

    // Randomized ack latencies (some beyond the timeout) and warm lengths.
    for (int it = 0; it < 4; it++) begin
      for (int k = 0; k < N; k++) dly[k] = $urandom_range(1, 80);
      cold_start(c0, d);
      do_warm(d, $urandom_range(1, 60), d2);
      goto_neg(d2 + 2);
      hard_reset(1'b1, "random");
    end

    // Single stage, GAP_CYC=1, no ack wait: acks are ignored throughout.
    @(negedge clk);
    rst1_n = 1'b1;
    @(posedge clk); #1;
    chk("s1_release_edge1", 32'({o1_rst, o1_done, o1_err}), 32'b100);
    @(negedge clk); ack1 = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    chk("s1_done_edge2", 32'({o1_rst, o1_done, o1_err}), 32'b110);
    chk("s1_cur_stage", 32'(o1_cur), 32'd0);
    @(negedge clk); warm1 = 1'b1; ack1 = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    chk("s1_warm_accept", 32'({o1_rst, o1_done, o1_err}), 32'b100);
    @(posedge clk); #1;
    chk("s1_warm_assert", 32'({o1_rst, o1_done, o1_err}), 32'b000);
    @(posedge clk); #1;
    chk("s1_wquiet_hold", 32'({o1_rst, o1_done, o1_err}), 32'b000);
    @(negedge clk); warm1 = 1'b0;
    @(posedge clk); #1;
    chk("s1_wquiet_exit", 32'({o1_rst, o1_done, o1_err}), 32'b000);
    @(posedge clk); #1;
    chk("s1_replay_release", 32'({o1_rst, o1_done, o1_err}), 32'b100);
    @(posedge clk); #1;
    chk("s1_replay_done", 32'({o1_rst, o1_done, o1_err}), 32'b110);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
